wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/riscv_pkg.sv | 16 +
 rtl/wb_scoreboard.sv | 32 +++
 rtl/wb_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared core constants and writeback source encoding.
// Imported by the writeback arbiter and its scoreboard.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NREG       = 32;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_LD,
    SRC_MD
  } wb_src_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard for long-latency results.
// A set and a clear of the same register in one cycle leaves it busy.
module wb_scoreboard #(
  parameter int NREG = riscv_pkg::NREG
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              set_en,
  input  logic [riscv_pkg::REG_ADDR_W-1:0]  set_rd,
  input  logic                              clr_en,
  input  logic [riscv_pkg::REG_ADDR_W-1:0]  clr_rd,
  output logic [NREG-1:0]                   busy
);

  import riscv_pkg::*;

  logic [NREG-1:0] busy_q;

  // Clear first, then set, so a same-cycle set wins; x0 never pends.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      if (clr_en) busy_q[clr_rd] <= 1'b0;
      if (set_en) busy_q[set_rd] <= 1'b1;
      busy_q[0] <= 1'b0;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU first, load and mul/div share a round-robin slot.
// Owns the registered write port, decode bypass and scoreboard hookup.
module wb_arbiter #(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int NREG = riscv_pkg::NREG
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              alu_valid,
  input  logic [riscv_pkg::REG_ADDR_W-1:0]  alu_rd,
  input  logic [XLEN-1:0]                   alu_data,
  input  logic                              ld_valid,
  output logic                              ld_ready,
  input  logic [riscv_pkg::REG_ADDR_W-1:0]  ld_rd,
  input  logic [XLEN-1:0]                   ld_data,
  input  logic                              md_valid,
  output logic                              md_ready,
  input  logic [riscv_pkg::REG_ADDR_W-1:0]  md_rd,
  input  logic [XLEN-1:0]                   md_data,
  input  logic                              issue_valid,
  input  logic [riscv_pkg::REG_ADDR_W-1:0]  issue_rd,
  output logic                              wb_wen,
  output logic [riscv_pkg::REG_ADDR_W-1:0]  wb_rd,
  output logic [XLEN-1:0]                   wb_data,
  input  logic [riscv_pkg::REG_ADDR_W-1:0]  rs1,
  input  logic [riscv_pkg::REG_ADDR_W-1:0]  rs2,
  output logic                              fwd1_hit,
  output logic [XLEN-1:0]                   fwd1_data,
  output logic                              fwd2_hit,
  output logic [XLEN-1:0]                   fwd2_data,
  output logic [NREG-1:0]                   busy
);

  import riscv_pkg::*;

  // ptr_q = 0 favours load, 1 favours mul/div
  logic                  ptr_q;
  logic                  both_valid;
  logic                  ld_fire;
  logic                  md_fire;
  wb_src_e               src;
  logic [REG_ADDR_W-1:0] sel_rd;
  logic [XLEN-1:0]       sel_data;
  logic                  sel_wr;
  logic                  clr_en;
  logic [REG_ADDR_W-1:0] clr_rd;
  logic                  set_en;

  assign both_valid = ld_valid && md_valid;

  assign ld_ready = !rst && !alu_valid && (!md_valid || !ptr_q);
  assign md_ready = !rst && !alu_valid && (!ld_valid ||  ptr_q);

  assign ld_fire = ld_valid && ld_ready;
  assign md_fire = md_valid && md_ready;

  // Pick which source, if any, is accepted this cycle.
  always_comb begin
    src = SRC_NONE;
    if (alu_valid && !rst) src = SRC_ALU;
    else if (ld_fire)      src = SRC_LD;
    else if (md_fire)      src = SRC_MD;
  end

  // Route the accepted source onto the write candidate.
  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    unique case (src)
      SRC_ALU: begin
        sel_rd   = alu_rd;
        sel_data = alu_data;
      end
      SRC_LD: begin
        sel_rd   = ld_rd;
        sel_data = ld_data;
      end
      SRC_MD: begin
        sel_rd   = md_rd;
        sel_data = md_data;
      end
      default: ;
    endcase
  end

  assign sel_wr = (src != SRC_NONE) && (sel_rd != '0);

  // Registered write port; rd/data hold when nothing is written.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_wen  <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else begin
      wb_wen <= sel_wr;
      if (sel_wr) begin
        wb_rd   <= sel_rd;
        wb_data <= sel_data;
      end
    end
  end

  // Round-robin pointer moves only after a contested handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (both_valid && (ld_fire || md_fire)) begin
      ptr_q <= ~ptr_q;
    end
  end

  assign set_en = issue_valid && (issue_rd != '0);
  assign clr_en = ld_fire || md_fire;
  assign clr_rd = ld_fire ? ld_rd : md_rd;

  wb_scoreboard #(
    .NREG (NREG)
  ) u_sb (
    .clk    (clk),
    .rst    (rst),
    .set_en (set_en),
    .set_rd (issue_rd),
    .clr_en (clr_en),
    .clr_rd (clr_rd),
    .busy   (busy)
  );

  assign fwd1_hit  = wb_wen && (wb_rd == rs1) && (rs1 != '0);
  assign fwd2_hit  = wb_wen && (wb_rd == rs2) && (rs2 != '0);
  assign fwd1_data = fwd1_hit ? wb_data : '0;
  assign fwd2_data = fwd2_hit ? wb_data : '0;

  // A stalled producer must keep its result steady until taken.
  ld_hold: assert property (@(posedge clk) disable iff (rst)
    ld_valid && !ld_ready |=>
      !ld_valid || ($stable(ld_rd) && $stable(ld_data)));

  md_hold: assert property (@(posedge clk) disable iff (rst)
    md_valid && !md_ready |=>
      !md_valid || ($stable(md_rd) && $stable(md_data)));

endmodule
